// File: rtl/fifo_order_arbiter_pkg.sv
// Shared types and width helpers for the first-come first-served arbiter.
package fifo_order_arbiter_pkg;

   typedef enum logic {IDLE, GRANT} state_e;

   // Default configuration
   localparam int N_DEF        = 4;
   localparam int MAX_HOLD_DEF = 8;

   // Width of an index into n entries. Never less than 1 bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of a counter that must hold the values 0..n.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// N-deep requester-ID queue.
// Several pushes per cycle are written in ascending ID order, and one pop per cycle is allowed.
// Entry 0 is always the head. A pop shifts the whole queue down by one entry.
module arb_id_fifo
   import fifo_order_arbiter_pkg::*;
#(
   parameter int N   = N_DEF,
   parameter int IDW = idx_w(N_DEF),
   parameter int CW  = cnt_w(N_DEF)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   push,
   input  logic           pop,
   output logic [IDW-1:0] head,
   output logic [CW-1:0]  count
);

   logic [N-1:0][IDW-1:0] mem_q, mem_d;
   logic [CW-1:0]         count_q, count_d;

   // Shift out the popped head, then append this cycle's arrivals behind the survivors
   always_comb begin
      int cnt;
      mem_d = mem_q;
      cnt   = int'(count_q);
      if (pop && (count_q != '0)) begin
         for (int i = 0; i < N - 1; i++) mem_d[i] = mem_q[i+1];
         mem_d[N-1] = '0;
         cnt        = cnt - 1;
      end
      for (int i = 0; i < N; i++) begin
         if (push[i]) begin
            // Each ID is queued at most once, so cnt < N always holds here
            if (cnt < N) mem_d[IDW'(cnt)] = IDW'(i);
            cnt = cnt + 1;
         end
      end
      count_d = CW'(cnt);
   end

   // Queue storage and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[0];
   assign count = count_q;

endmodule

// File: rtl/fifo_order_arbiter.sv
// Grants one shared resource to N requesters in order of request arrival.
// A grant is held until the requester drops req or the hold limit is reached.
module fifo_order_arbiter
   import fifo_order_arbiter_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [idx_w(N)-1:0]  grant_id,
   output logic                 busy,
   output logic                 timeout,
   output logic [cnt_w(N)-1:0]  queue_count
);

   localparam int IDW = idx_w(N);
   localparam int CW  = cnt_w(N);
   localparam int HW  = cnt_w(MAX_HOLD);

   state_e         state_q, state_d;
   logic [N-1:0]   req_prev_q, queued_q, queued_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic           busy_q, busy_d;
   logic           timeout_q, timeout_d;

   logic [N-1:0]   push, pop_mask;
   logic           pop;
   logic [IDW-1:0] head;
   logic [CW-1:0]  count;

   // A new arrival is a rising req edge from an ID that is not already waiting
   assign push     = req & ~req_prev_q & ~queued_q;
   assign pop      = (state_q == IDLE) && (count != '0);
   assign pop_mask = pop ? (N'(1) << head) : '0;
   assign queued_d = (queued_q | push) & ~pop_mask;

   arb_id_fifo #(.N(N), .IDW(IDW), .CW(CW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .head  (head),
      .count (count)
   );

   // Next state, next grant and hold counter
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      hold_d     = hold_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               // A withdrawn head is discarded, and that still uses up this cycle
               if (req[head]) begin
                  grant_d    = N'(1) << head;
                  grant_id_d = head;
                  hold_d     = HW'(1);
                  state_d    = GRANT;
               end
            end
         end
         GRANT: begin
            if (!req[grant_id_q]) begin
               grant_d    = '0;
               grant_id_d = '0;
               hold_d     = '0;
               state_d    = IDLE;
            end else if (hold_q == HW'(MAX_HOLD)) begin
               grant_d    = '0;
               grant_id_d = '0;
               hold_d     = '0;
               timeout_d  = 1'b1;
               state_d    = IDLE;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = |grant_d;
   end

   // State, edge-detect history and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_prev_q <= '0;
         queued_q   <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         hold_q     <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_prev_q <= req;
         queued_q   <= queued_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         hold_q     <= hold_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign timeout     = timeout_q;
   assign queue_count = count;

endmodule

// File: doc/fifo_order_arbiter.md
# fifo_order_arbiter

- Grants one shared resource to N requesters strictly in order of request arrival (first-come, first-served), not by fixed priority.
- Extends the team's two-requester grant controller to N ports, with held grants, forced release after a hold limit, and withdrawal of pending requests.
- Sits between requester blocks and the shared resource; grant outputs drive the resource's select/enable.

## Interface
- N, default 4: number of requesters, 2..16.
- MAX_HOLD, default 8: maximum consecutive cycles one grant may be held, ≥1.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N  level request per requester; held high while the resource is wanted.
- grant  out  N  one-hot (or zero) registered grant.
- grant_id  out  $clog2(N)  index of current holder; 0 when no grant.
- busy  out  1  high while any grant is asserted.
- timeout  out  1  one-cycle pulse when a grant is force-released at MAX_HOLD.
- queue_count  out  $clog2(N+1)  number of entries in the arrival queue.

## Operation
- Arrival: req[i] sampled 1 with previous sample 0 and queued[i]=0 → push ID i into the arrival queue.
  - Same-edge arrivals are pushed in ascending index order.
  - A rising edge while queued[i]=1 is ignored.
- Queue capacity is N. Each ID is queued at most once, so overflow cannot occur.
- queued[i] clears when ID i is popped.
- States: IDLE, GRANT.
- IDLE, queue non-empty:
  - Pop head h.
  - If req[h]=1: grant[h]←1, grant_id←h, hold counter←1, go to GRANT.
  - If req[h]=0 (withdrawn): discard h, stay IDLE, no grant. This consumes the cycle.
- IDLE, queue empty: stay IDLE.
- GRANT, release condition (priority order):
  1. req[holder]=0 → grant←0, go to IDLE.
  2. Else hold counter = MAX_HOLD → grant←0, timeout←1 for one cycle, go to IDLE.
  3. Else hold counter increments and the grant stays.
- A requester that keeps req high after a forced release is not re-queued until req drops and rises again. Edge detection enforces this.
- Pushes and the pop happen on the same edge without conflict. queue_count = old + pushes − pop.
- Hold counter width is $clog2(MAX_HOLD+1). It never exceeds MAX_HOLD.

## Timing
- Reset asserted (any time, including mid-grant):
  - grant=0, grant_id=0, busy=0, timeout=0, queue_count=0.
  - State IDLE, queue and queued[] cleared, previous-req samples cleared.
  - These take effect immediately, asynchronously.
- A req held high across reset deassertion counts as an arrival at the first clock edge.
- Latency, idle arbiter:
  - req rises before edge k → pushed at edge k → grant high after edge k+1 (2 cycles).
- Release latency:
  - Holder drops req before edge k → grant low after edge k.
  - The next queued requester is granted after edge k+1. There is exactly one dead cycle between grants.
- With MAX_HOLD=M and req never dropping, grant is high for exactly M cycles. timeout is high in the cycle after the last grant cycle.
- All outputs are registered. No combinational path from req to grant.

## Structure
- Package fifo_order_arbiter_pkg:
  - State enum {IDLE, GRANT}.
  - Width helper constants derived from N and MAX_HOLD.
- Sub-module arb_id_fifo: N-deep ID queue with multi-push (ascending order), single pop, and a count output.
- Top level holds the edge detect, queued[] bits, FSM, hold counter, and output registers.

## Test plan
- Single request, N=4, MAX_HOLD=8:
  - req[2] rises before edge 1 → grant=4'b0100 after edge 2, grant_id=2.
  - req[2] drops before edge 5 → grant=0 after edge 5.
- Arrival order:
  - req[3] rises at edge 1, req[0] at edge 2, req[1] at edge 3, each held until granted then released after 2 cycles.
  - Required grant order 3,0,1, with one dead cycle between grants.
- Simultaneous arrival:
  - req=4'b1010 rises at one edge → queue_count=2; grants go to 1, then 3.
- Forced release, MAX_HOLD=3:
  - req[0] held high → grant[0] high for exactly 3 cycles, timeout pulses once, no re-grant.
  - After req[0] drops and rises again → re-queued and granted.
- Withdrawal:
  - req[1] and req[2] queued behind holder 0; req[1] drops while queued.
  - After 0 releases → one skip cycle, then grant[2]. ID 1 is never granted.
- Reset mid-grant:
  - Assert reset while grant[3]=1 and queue_count=2 → all outputs 0 immediately.
  - After release with all req low, outputs stay 0.
